// File: rtl/can_crc_engine.sv
// CAN CRC-15 engine: accumulates a framed bit stream, MSB first, DATA_W bits per beat,
// and presents the CRC (plus an optional compare-against-received flag) once per frame.
module can_crc_engine #(
    parameter int DATA_W = 8,
    parameter int NB_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_last,
    input  logic [NB_W-1:0]   in_nbits,
    input  logic              chk_en,
    input  logic [14:0]       crc_ref,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [14:0]       crc_out,
    output logic              crc_err,
    output logic              busy
);

    localparam logic [14:0] CRC_POLY = 15'h4599;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [14:0] r_crc;
    logic        r_crcErr;
    logic [14:0] w_crcNew;
    logic        w_accept;
    logic        w_load;
    int          w_nUse;

    // One serial CRC-15 step for a single frame bit.
    function automatic logic [14:0] crcStep(input logic [14:0] crcIn, input logic dataBit);
        logic        nxt;
        logic [14:0] crcTmp;
        nxt    = dataBit ^ crcIn[14];
        crcTmp = {crcIn[13:0], 1'b0};
        if (nxt) begin
            crcTmp = crcTmp ^ CRC_POLY;
        end
        return crcTmp;
    endfunction

    // A beat is taken whenever we are not holding a result; it only touches the CRC
    // when it starts a frame or continues one that is already open.
    assign w_accept = in_valid && (r_state != HOLD);
    assign w_load   = w_accept && (in_sof || (r_state == ACCUM));

    // Number of leading bits of this beat that belong to the frame; only a last beat can be short.
    always_comb begin
        w_nUse = DATA_W;
        if (in_last && (in_nbits != '0) && (int'(in_nbits) < DATA_W)) begin
            w_nUse = int'(in_nbits);
        end
    end

    // Unrolled CRC over the used bits of the beat, MSB first; a start-of-frame reseeds from zero.
    always_comb begin
        w_crcNew = in_sof ? 15'h0000 : r_crc;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < w_nUse) begin
                w_crcNew = crcStep(w_crcNew, in_data[DATA_W-1-i]);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: open a frame on sof, close it on last, release the result on out_ready.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && in_sof) begin
                    w_nextState = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && in_last) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // CRC accumulator and check flag; the flag is decided once, when the last beat lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc    <= 15'h0000;
            r_crcErr <= 1'b0;
        end else if (w_load) begin
            r_crc <= w_crcNew;
            if (in_last) begin
                r_crcErr <= chk_en && (w_crcNew != crc_ref);
            end
        end
    end

    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign crc_out   = r_crc;
    assign crc_err   = r_crcErr;

endmodule

// File: tb/tb_can_crc_engine.sv
// Self-checking bench for can_crc_engine: directed corner cases plus randomized frames
// compared against a polynomial long-division model of CRC-15.
module tb_can_crc_engine;

    localparam int DATA_W = 8;
    localparam int NB_W   = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic              in_last;
    logic [NB_W-1:0]   in_nbits;
    logic              chk_en;
    logic [14:0]       crc_ref;
    logic              out_valid;
    logic              out_ready;
    logic [14:0]       crc_out;
    logic              crc_err;
    logic              busy;

    int testsRun  = 0;
    int failCount = 0;

    bit          modelBits[$];
    bit          modelActive = 1'b0;
    bit          frameDone;
    logic [14:0] expCrc = 15'h0000;
    logic        expErr;

    can_crc_engine #(.DATA_W(DATA_W), .NB_W(NB_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .in_last  (in_last),
        .in_nbits (in_nbits),
        .chk_en   (chk_en),
        .crc_ref  (crc_ref),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .crc_out  (crc_out),
        .crc_err  (crc_err),
        .busy     (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time guard so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // CRC as remainder of M(x)*x^15 divided by x^15+0x4599, done by long division.
    function automatic logic [14:0] polyDivide();
        logic [15:0] rem;
        rem = 16'h0000;
        for (int i = 0; i < modelBits.size() + 15; i++) begin
            rem = {rem[14:0], (i < modelBits.size()) ? modelBits[i] : 1'b0};
            if (rem[15]) rem = rem ^ 16'hC599;
        end
        return rem[14:0];
    endfunction

    // Drive one beat for one clock, updating the frame model by the framing rules.
    task automatic applyStimulus(input logic [7:0] data, input logic sof, input logic last,
                                 input logic [3:0] nbits, input logic chk,
                                 input logic matchRef, input logic [14:0] refVal);
        int n;
        n = DATA_W;
        if (last && nbits != 0 && nbits < DATA_W) n = nbits;
        frameDone = 1'b0;
        if (sof) begin
            modelBits.delete();
            modelActive = 1'b1;
        end
        if (modelActive) begin
            for (int i = 0; i < n; i++) modelBits.push_back(data[DATA_W-1-i]);
            if (last) begin
                expCrc      = polyDivide();
                frameDone   = 1'b1;
                modelActive = 1'b0;
            end
        end
        in_data  = data;
        in_sof   = sof;
        in_last  = last;
        in_nbits = nbits;
        chk_en   = chk;
        crc_ref  = (matchRef && frameDone) ? expCrc : refVal;
        if (frameDone) expErr = chk && (expCrc != crc_ref);
        in_valid = 1'b1;
        checkOutput("in_ready_before_beat", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_last  = 1'b0;
        chk_en   = 1'b0;
    endtask

    // Verify the held result, stall for some cycles, then release it.
    task automatic checkResult(input int stall);
        checkOutput("out_valid_after_last", out_valid, 1);
        checkOutput("crc_out", crc_out, expCrc);
        checkOutput("crc_err", crc_err, expErr);
        checkOutput("in_ready_hold", in_ready, 0);
        checkOutput("busy_hold", busy, 1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            checkOutput("out_valid_stall", out_valid, 1);
            checkOutput("crc_out_stall", crc_out, expCrc);
            checkOutput("crc_err_stall", crc_err, expErr);
            checkOutput("in_ready_stall", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_release", out_valid, 0);
        checkOutput("in_ready_release", in_ready, 1);
        checkOutput("busy_release", busy, 0);
        checkOutput("crc_out_kept", crc_out, expCrc);
    endtask

    // Directed cases followed by randomized frames.
    initial begin
        int          nBeats;
        logic [7:0]  rData;
        logic        rSof;
        logic        rLast;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_last = 1'b0;
        in_nbits = '0; chk_en = 1'b0; crc_ref = '0; out_ready = 1'b0; expErr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_crc_out", crc_out, 0);
        checkOutput("reset_crc_err", crc_err, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        applyStimulus(8'h01, 1, 1, 0, 0, 0, 15'h0);
        checkOutput("single_beat_const", crc_out, 15'h4599);
        checkResult(0);

        applyStimulus(8'h00, 1, 0, 0, 0, 0, 15'h0);
        checkOutput("accum_busy", busy, 1);
        checkOutput("accum_no_valid", out_valid, 0);
        applyStimulus(8'h01, 0, 1, 0, 0, 0, 15'h0);
        checkOutput("two_beat_const", crc_out, 15'h4599);
        checkResult(0);
        applyStimulus(8'h00, 1, 0, 0, 0, 0, 15'h0);
        applyStimulus(8'h00, 0, 1, 0, 0, 0, 15'h0);
        checkOutput("zero_frame_const", crc_out, 15'h0000);
        checkResult(0);

        applyStimulus(8'h80, 1, 1, 1, 0, 0, 15'h0);
        checkOutput("nbits1_80_const", crc_out, 15'h4599);
        checkResult(0);
        applyStimulus(8'hFF, 1, 1, 1, 0, 0, 15'h0);
        checkOutput("nbits1_ff_const", crc_out, 15'h4599);
        checkResult(0);

        applyStimulus(8'h01, 1, 1, 0, 1, 0, 15'h4599);
        checkOutput("chk_match_const", crc_err, 0);
        checkResult(0);
        applyStimulus(8'h01, 1, 1, 0, 1, 0, 15'h4598);
        checkOutput("chk_mismatch_const", crc_err, 1);
        checkResult(3);

        applyStimulus(8'h37, 1, 0, 0, 0, 0, 15'h0);
        applyStimulus(8'h01, 1, 1, 0, 0, 0, 15'h0);
        checkOutput("abort_restart_const", crc_out, 15'h4599);
        checkResult(0);

        applyStimulus(8'h55, 1, 0, 0, 0, 0, 15'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelActive = 1'b0;
        expCrc = 15'h0000;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_crc_out", crc_out, 0);
        applyStimulus(8'h12, 0, 1, 0, 0, 0, 15'h0);
        checkOutput("idle_nosof_busy", busy, 0);
        checkOutput("idle_nosof_valid", out_valid, 0);
        checkOutput("idle_nosof_crc", crc_out, expCrc);

        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(8'($urandom_range(0, 255)), 0, 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 15)), 0, 0, 15'h0);
                checkOutput("rand_discard_busy", busy, 0);
                checkOutput("rand_discard_crc", crc_out, expCrc);
            end
            nBeats = $urandom_range(1, 5);
            for (int b = 0; b < nBeats; b++) begin
                rData = 8'($urandom_range(0, 255));
                rSof  = (b == 0) || ($urandom_range(0, 7) == 0);
                rLast = (b == nBeats - 1);
                applyStimulus(rData, rSof, rLast, 4'($urandom_range(0, 15)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              15'($urandom_range(0, 32767)));
                if (!rLast) checkOutput("rand_mid_valid", out_valid, 0);
            end
            checkResult($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/can_crc_engine.md
CAN_CRC_ENGINE -- requirements
Module: can_crc_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per input beat (legal range 1..64).
REQ-002 SHALL have parameter NB_W, default $clog2(DATA_W+1), meaning width of in_nbits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  frame bits, MSB (bit DATA_W-1) transmitted first.
REQ-008 SHALL have port in_sof  input  1  beat is first of frame.
REQ-009 SHALL have port in_last  input  1  beat is last of frame.
REQ-010 SHALL have port in_nbits  input  NB_W  valid bits on last beat, counted from MSB; 0 means DATA_W.
REQ-011 SHALL have port chk_en  input  1  check mode, sampled on last beat.
REQ-012 SHALL have port crc_ref  input  15  received CRC to compare, sampled on last beat.
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  consumer takes result.
REQ-015 SHALL have port crc_out  output  15  CRC-15 of frame.
REQ-016 SHALL have port crc_err  output  1  check-mode mismatch flag.
REQ-017 SHALL have port busy  output  1  frame in progress (state ACCUM or HOLD).

Function
REQ-018 SHALL implement the CAN CRC-15: polynomial 0x4599, init 0x0000; per bit b: nxt=b^crc[14]; crc={crc[13:0],0}; if nxt, crc^=0x4599.
REQ-019 SHALL process all DATA_W bits of one accepted beat in one cycle (unrolled), MSB first.
REQ-020 SHALL have states IDLE, ACCUM, HOLD; in_ready=1 in IDLE and ACCUM, 0 in HOLD.
REQ-021 A beat SHALL be accepted on in_valid&in_ready.
REQ-022 IDLE: accepted beat with in_sof SHALL load crc from init over the beat; with in_last go HOLD, else go ACCUM.
REQ-023 IDLE: accepted beat without in_sof SHALL be discarded, with state and crc unchanged.
REQ-024 ACCUM: accepted beat without in_sof SHALL update crc; with in_last go HOLD.
REQ-025 ACCUM: accepted beat with in_sof SHALL abort the current frame and restart from init over this beat (simultaneous in_sof+in_last -> HOLD).
REQ-026 Non-last beats SHALL use all DATA_W bits; the last beat SHALL use the top in_nbits bits (0 -> DATA_W), and the remaining bits SHALL be ignored.
REQ-027 in_nbits greater than DATA_W SHALL be treated as DATA_W.
REQ-028 Latency: out_valid SHALL assert the cycle after the last-beat acceptance, with crc_out final.
REQ-029 HOLD: out_valid, crc_out and crc_err SHALL stay stable until out_valid&out_ready; then go IDLE, out_valid=0 next cycle.
REQ-030 crc_err SHALL equal latched chk_en AND (crc != latched crc_ref); crc_err=0 when chk_en was 0.
REQ-031 crc_out SHALL hold the last result after HOLD exits, until the next frame updates it.
REQ-032 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-033 On rst=1 at a clk edge: state=IDLE, crc=0x0000, out_valid=0, crc_err=0, crc_out=0x0000, busy=0, in_ready=1 from next cycle.
REQ-034 rst SHALL override any in-flight beat or held result; the partial frame SHALL be lost without out_valid.

Verification
REQ-035 DATA_W=8: one beat 0x01, sof=1, last=1, nbits=0 -> next cycle out_valid=1, crc_out=0x4599, crc_err=0.
REQ-036 DATA_W=8: beats 0x00(sof), 0x01(last) -> crc_out=0x4599; beats 0x00(sof), 0x00(last) -> crc_out=0x0000.
REQ-037 DATA_W=8: beat 0x80, sof+last, nbits=1 -> crc_out=0x4599 (low 7 bits ignored); with data 0xFF and nbits=1 -> same result.
REQ-038 Check mode: REQ-035 frame with chk_en=1, crc_ref=0x4599 -> crc_err=0; with crc_ref=0x4598 -> crc_err=1.
REQ-039 Backpressure: out_ready=0 for 3 cycles in HOLD -> out_valid, crc_out and crc_err stable and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-040 Abort/reset: in ACCUM, a beat 0x01 with sof+last -> crc_out=0x4599; rst mid-ACCUM -> busy=0 and out_valid=0; a beat without sof in IDLE -> ignored.
